// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: decoder ALU op codes,
// sequencer state encoding and the two's-complement magnitude helper.
package riscv_pkg;

  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_MULH = 4'd11;
  localparam logic [3:0] ALU_DIV  = 4'd12;
  localparam logic [3:0] ALU_REM  = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } md_state_e;

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/riscv_muldiv_iter.sv
// 64-bit accumulator datapath shared by the shift-add multiplier and the restoring
// divider: load, one-bit step, and sign fix-up of the selected result word.
module riscv_muldiv_iter (
  input  logic        clk_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        is_div_i,
  input  logic        sel_hi_i,
  input  logic        neg_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_o
);

  logic [63:0] acc_q, acc_d, stepped, prod;
  logic [31:0] a_q, a_d, word;
  logic [32:0] sum, diff;

  // res_o is taken from the next accumulator so the final step's result can be registered at once.
  always_comb begin
    sum     = {1'b0, acc_q[63:32]} + {1'b0, a_q};
    diff    = acc_q[63:31] - {1'b0, a_q};
    stepped = acc_q;
    if (is_div_i) begin
      stepped = diff[32] ? {acc_q[62:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      stepped = acc_q[0] ? {sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
    end

    acc_d = acc_q;
    a_d   = a_q;
    if (load_i) begin
      acc_d = {32'd0, b_i};
      a_d   = a_i;
    end else if (step_i) begin
      acc_d = stepped;
    end

    prod = acc_d;
    word = acc_d[31:0];
    if (is_div_i) begin
      word = sel_hi_i ? acc_d[63:32] : acc_d[31:0];
      if (neg_i) word = ~word + 32'd1;
    end else begin
      if (neg_i) prod = ~acc_d + 64'd1;
      word = sel_hi_i ? prod[63:32] : prod[31:0];
    end
    res_o = word;
  end

  always_ff @(posedge clk_i) begin
    acc_q <= acc_d;
    a_q   <= a_d;
  end

endmodule

// File: rtl/riscv_muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer (IDLE/MUL/DIV/DONE). Define RISCV_FAST_MUL_EN
// to replace the 32-cycle shift-add multiply with a one-cycle 33x33 signed multiplier.
module riscv_muldiv_seq
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [3:0]  alu_op_i,
  input  logic        mulh_i,
  input  logic        mulhsu_i,
  input  logic        div_i,
  input  logic        rem_i,
  input  logic [31:0] ra_i,
  input  logic [31:0] rb_i,
  input  logic [4:0]  rd_index_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_index_o
);

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d, rd_q, rd_d;
  logic        is_div_q, is_div_d, sel_hi_q, sel_hi_d, neg_q, neg_d, valid_q, valid_d;
  logic [31:0] result_q, result_d, iter_res, dec_a, dec_b, spec_res;
  logic        dec_neg, dec_hi, dec_signed, div_zero, div_ovf, special;
  logic        is_md_op, is_div_op, accept, load, step;
`ifdef RISCV_FAST_MUL_EN
  logic signed [32:0] fa_q, fa_d, fb_q, fb_d;
  logic signed [63:0] fprod;

  assign fprod = 64'(fa_q) * 64'(fb_q);
`endif

  assign is_md_op   = alu_op_i inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
  assign is_div_op  = (alu_op_i == ALU_DIV) || (alu_op_i == ALU_REM);
  assign ready_o    = (state_q == S_IDLE) && !rst_i;
  assign busy_o     = (state_q != S_IDLE);
  assign valid_o    = valid_q && !flush_i;
  assign result_o   = result_q;
  assign rd_index_o = rd_q;
  assign accept     = valid_i && ready_o && is_md_op && !flush_i;

  // Signed variants run on magnitudes; dec_neg records whether the result must be negated.
  always_comb begin
    dec_a      = ra_i;
    dec_b      = rb_i;
    dec_neg    = 1'b0;
    dec_hi     = 1'b0;
    dec_signed = 1'b0;
    case (alu_op_i)
      ALU_MULH: begin
        dec_hi = 1'b1;
        if (mulh_i) begin
          dec_a   = mag32(ra_i);
          dec_b   = mag32(rb_i);
          dec_neg = ra_i[31] ^ rb_i[31];
        end else if (mulhsu_i) begin
          dec_a   = mag32(ra_i);
          dec_neg = ra_i[31];
        end
      end
      ALU_DIV, ALU_REM: begin
        dec_signed = (alu_op_i == ALU_DIV) ? div_i : rem_i;
        dec_hi     = (alu_op_i == ALU_REM);
        dec_a      = dec_signed ? mag32(rb_i) : rb_i;
        dec_b      = dec_signed ? mag32(ra_i) : ra_i;
        dec_neg    = dec_signed && ((alu_op_i == ALU_DIV) ? (ra_i[31] ^ rb_i[31]) : ra_i[31]);
      end
      default: ;
    endcase
    div_zero = (rb_i == 32'd0);
    div_ovf  = dec_signed && (ra_i == 32'h8000_0000) && (rb_i == 32'hFFFF_FFFF);
    special  = is_div_op && (div_zero || div_ovf);
    if (div_zero) spec_res = (alu_op_i == ALU_DIV) ? 32'hFFFF_FFFF : ra_i;
    else          spec_res = (alu_op_i == ALU_DIV) ? 32'h8000_0000 : 32'd0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    is_div_d = is_div_q;
    sel_hi_d = sel_hi_q;
    neg_d    = neg_q;
    result_d = result_q;
    valid_d  = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
`ifdef RISCV_FAST_MUL_EN
    fa_d = fa_q;
    fb_d = fb_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rd_d     = rd_index_i;
          is_div_d = is_div_op;
          sel_hi_d = dec_hi;
          neg_d    = dec_neg;
          cnt_d    = 5'd0;
`ifdef RISCV_FAST_MUL_EN
          fa_d = {(alu_op_i == ALU_MULH) && (mulh_i || mulhsu_i) && ra_i[31], ra_i};
          fb_d = {(alu_op_i == ALU_MULH) && mulh_i && rb_i[31], rb_i};
`endif
          if (special) begin
            result_d = spec_res;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end else begin
            load    = 1'b1;
            state_d = is_div_op ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL: begin
`ifdef RISCV_FAST_MUL_EN
        result_d = sel_hi_q ? fprod[63:32] : fprod[31:0];
        valid_d  = 1'b1;
        state_d  = S_DONE;
`else
        step  = 1'b1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = iter_res;
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end
`endif
      end
      S_DIV: begin
        step  = 1'b1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = iter_res;
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A redirect abandons the op; the previous result stays visible.
    if (flush_i && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      result_q <= 32'd0;
      rd_q     <= 5'd0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
    cnt_q    <= cnt_d;
    is_div_q <= is_div_d;
    sel_hi_q <= sel_hi_d;
    neg_q    <= neg_d;
`ifdef RISCV_FAST_MUL_EN
    fa_q <= fa_d;
    fb_q <= fb_d;
`endif
  end

  riscv_muldiv_iter u_iter (
    .clk_i    (clk_i),
    .load_i   (load),
    .step_i   (step),
    .is_div_i (is_div_q),
    .sel_hi_i (sel_hi_q),
    .neg_i    (neg_q),
    .a_i      (dec_a),
    .b_i      (dec_b),
    .res_o    (iter_res)
  );

endmodule

// File: tb/tb_riscv_muldiv_seq.sv
// Self-checking bench for riscv_muldiv_seq: directed RV32M vectors against a plain-arithmetic
// model, with per-cycle checks of valid/busy/ready/result timing.
`timescale 1ns/1ps
module tb_riscv_muldiv_seq;

  logic        clk = 1'b0, rst_i = 1'b1, valid_i = 1'b0, flush_i = 1'b0;
  logic        mulh_i = 1'b0, mulhsu_i = 1'b0, div_i = 1'b0, rem_i = 1'b0;
  logic [3:0]  alu_op_i = 4'd0;
  logic [31:0] ra_i = 32'd0, rb_i = 32'd0;
  logic [4:0]  rd_index_i = 5'd0;
  logic        ready_o, busy_o, valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_index_o;

  int checks = 0, errors = 0, cyc = 0;
  int exp_due = -1, busy_from = -1, busy_to = -1, clear_at = -1;
  logic [31:0] exp_res = 32'd0, last_res = 32'd0;
  logic [4:0]  exp_rd = 5'd0;
  bit chk_en = 1'b0;
`ifdef RISCV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif

  riscv_muldiv_seq dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .alu_op_i(alu_op_i),
    .mulh_i(mulh_i), .mulhsu_i(mulhsu_i), .div_i(div_i), .rem_i(rem_i),
    .ra_i(ra_i), .rb_i(rb_i), .rd_index_i(rd_index_i), .flush_i(flush_i),
    .ready_o(ready_o), .busy_o(busy_o), .valid_o(valid_o),
    .result_o(result_o), .rd_index_o(rd_index_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference results straight from the RV32M definitions using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [3:0] op, input logic mh, mhsu, dv, rm,
                                        input logic [31:0] a, b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 64'd0;
    case (op)
      4'd10: begin p = ua * ub; return p[31:0]; end
      4'd11: begin
        if (mh) p = sa * sb;
        else if (mhsu) p = sa * ub;
        else p = ua * ub;
        return p[63:32];
      end
      4'd12: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (!dv) return a / b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      4'd13: begin
        if (b == 32'd0) return a;
        if (!rm) return a % b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin : cmp
      bit b;
      if (cyc == clear_at) last_res = 32'd0;
      b = (cyc >= busy_from) && (cyc <= busy_to);
      chk("busy_o", 32'(busy_o), 32'(b));
      chk("ready_o", 32'(ready_o), 32'(!b && !rst_i));
      chk("valid_o", 32'(valid_o), 32'(cyc == exp_due));
      if (cyc == exp_due) begin
        chk("result_o", result_o, exp_res);
        chk("rd_index_o", 32'(rd_index_o), 32'(exp_rd));
        last_res = exp_res;
      end else begin
        chk("result_hold", result_o, last_res);
      end
    end
  end

  // Presents one op for one cycle and records what the DUT must do; returns in the cycle after accept.
  task automatic start(input logic [3:0] op, input logic mh, mhsu, dv, rm,
                       input logic [31:0] a, b, input logic [4:0] rd, output int lat);
    bit sgn;
    @(posedge clk); #1;
    alu_op_i = op; mulh_i = mh; mulhsu_i = mhsu; div_i = dv; rem_i = rm;
    ra_i = a; rb_i = b; rd_index_i = rd; valid_i = 1'b1;
    sgn = (op == 4'd12) ? dv : rm;
    if (op < 4'd12) lat = MUL_LAT;
    else if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) lat = 1;
    else lat = 33;
    exp_res = model(op, mh, mhsu, dv, rm, a, b);
    exp_rd = rd;
    exp_due = cyc + lat;
    busy_from = cyc + 1;
    busy_to = cyc + lat;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic mh, mhsu, dv, rm,
                       input logic [31:0] a, b, input logic [4:0] rd);
    int lat;
    start(op, mh, mhsu, dv, rm, a, b, rd, lat);
    repeat (lat) @(posedge clk);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk); #1;
    chk("ready_in_reset", 32'(ready_o), 32'd0);
    chk("busy_reset", 32'(busy_o), 32'd0);
    chk("valid_reset", 32'(valid_o), 32'd0);
    chk("result_reset", result_o, 32'd0);
    chk("rd_reset", 32'(rd_index_o), 32'd0);
    rst_i = 1'b0;
    chk_en = 1'b1;

    chk("pin_mul", model(4'd10, 0, 0, 0, 0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("pin_mulh", model(4'd11, 1, 0, 0, 0, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("pin_mulhu", model(4'd11, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("pin_mulhsu", model(4'd11, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    chk("pin_div", model(4'd12, 0, 0, 1, 0, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem", model(4'd13, 0, 0, 0, 1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_remu", model(4'd13, 0, 0, 0, 0, 32'd100, 32'd7), 32'd2);

    issue(4'd10, 0, 0, 0, 0, 32'd7, 32'hFFFF_FFFD, 5'd9);
    issue(4'd11, 1, 0, 0, 0, 32'h8000_0000, 32'h8000_0000, 5'd1);
    issue(4'd11, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    issue(4'd11, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'd2, 5'd3);
    issue(4'd11, 1, 0, 0, 0, 32'h1234_5678, 32'hFEDC_BA98, 5'd4);
    issue(4'd12, 0, 0, 1, 0, 32'hFFFF_FFF9, 32'd2, 5'd5);
    issue(4'd13, 0, 0, 0, 1, 32'hFFFF_FFF9, 32'd2, 5'd6);
    issue(4'd12, 0, 0, 0, 0, 32'd100, 32'd7, 5'd7);
    issue(4'd13, 0, 0, 0, 0, 32'd100, 32'd7, 5'd0);
    issue(4'd12, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 5'd8);
    issue(4'd12, 0, 0, 1, 0, 32'd5, 32'd0, 5'd10);
    issue(4'd13, 0, 0, 0, 1, 32'd5, 32'd0, 5'd11);
    issue(4'd12, 0, 0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    issue(4'd13, 0, 0, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);

    // Non-M op and a flush racing valid_i in IDLE must both be ignored.
    @(posedge clk); #1;
    alu_op_i = 4'd3; valid_i = 1'b1;
    @(posedge clk); #1;
    alu_op_i = 4'd10; flush_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);

    // Flush at iteration 10 of a divide, then a fresh multiply.
    start(4'd12, 0, 0, 0, 0, 32'd1000, 32'd3, 5'd14, lat);
    repeat (9) @(posedge clk); #1;
    flush_i = 1'b1; busy_to = cyc; exp_due = -1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("ready_after_flush", 32'(ready_o), 32'd1);
    issue(4'd10, 0, 0, 0, 0, 32'd3, 32'd4, 5'd15);

    // Reset in the middle of a divide.
    start(4'd12, 0, 0, 1, 0, 32'hFFFF_FFF9, 32'd2, 5'd16, lat);
    repeat (4) @(posedge clk); #1;
    rst_i = 1'b1; busy_to = cyc; exp_due = -1; clear_at = cyc + 1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("rst_mid_rd", 32'(rd_index_o), 32'd0);
    chk("rst_mid_result", result_o, 32'd0);
    chk("rst_mid_valid", 32'(valid_o), 32'd0);
    repeat (40) @(posedge clk);

    // Back-to-back with valid_i held: operands changed while busy belong to the second op.
    start(4'd10, 0, 0, 0, 0, 32'd5, 32'd6, 5'd17, lat);
    valid_i = 1'b1; ra_i = 32'd9; rb_i = 32'd11; rd_index_i = 5'd18;
    repeat (lat) @(posedge clk); #1;
    exp_res = model(4'd10, 0, 0, 0, 0, 32'd9, 32'd11);
    exp_rd = 5'd18; exp_due = cyc + lat; busy_from = cyc + 1; busy_to = cyc + lat;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (lat + 3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
